// File: rtl/jk_updown_range_counter.sv
// Range counter over MIN_VAL..MAX_VAL with up/down wrap, sync load and terminal count, built from JK cells.
// Optional JK_CNT_GRAY_EN adds a registered Gray-coded copy of the count (count_gray).
module jk_updown_range_counter #(
    parameter int WIDTH       = 3,
    parameter int MIN_VAL     = 1,
    parameter int MAX_VAL     = 7,
    parameter int RESET_VALUE = 7
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
`ifdef JK_CNT_GRAY_EN
    output logic [WIDTH-1:0] count_gray,
`endif
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (WIDTH < 2) begin : g_bad_width
        $error("jk_updown_range_counter: WIDTH must be >= 2");
    end
    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= (2 ** WIDTH) - 1)) begin : g_bad_range
        $error("jk_updown_range_counter: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end
    if (RESET_VALUE < MIN_VAL || RESET_VALUE > MAX_VAL) begin : g_bad_reset
        $error("jk_updown_range_counter: RESET_VALUE must lie within [MIN_VAL, MAX_VAL]");
    end

    localparam logic [WIDTH-1:0] MIN_C   = MIN_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_C   = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_C = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] jk_nxt;
    logic             count_bad;
    logic             load_ok;
    logic             wrap_nxt;
    logic             err_nxt;

    assign count_bad = (count_q < MIN_C) || (count_q > MAX_C);
    assign load_ok   = (load_val >= MIN_C) && (load_val <= MAX_C);

    // Self-correction outranks load and enable so a corrupted count always recovers.
    always_comb begin
        nxt      = count_q;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (count_bad) begin
            nxt = MIN_C;
        end else if (load) begin
            if (load_ok) begin
                nxt = load_val;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                if (count_q == MAX_C) begin
                    nxt      = MIN_C;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == MIN_C) begin
                    nxt      = MAX_C;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Each bit is a JK cell steered toward nxt.
    assign j      = nxt & ~count_q;
    assign k      = ~nxt & count_q;
    assign jk_nxt = (j & ~count_q) | (~k & count_q);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count_q  <= RESET_C;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count_q  <= jk_nxt;
            wrap     <= wrap_nxt;
            load_err <= err_nxt;
        end
    end

`ifdef JK_CNT_GRAY_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count_gray <= RESET_C ^ (RESET_C >> 1);
        end else begin
            count_gray <= jk_nxt ^ (jk_nxt >> 1);
        end
    end
`endif

    assign count = count_q;
    assign tc    = en & ~load & (up_dn ? (count_q == MAX_C) : (count_q == MIN_C));

endmodule

// File: tb/tb_jk_updown_range_counter.sv
// Directed bench for jk_updown_range_counter at default parameters; scoreboard queue checked by a monitor.
module tb_jk_updown_range_counter;

    localparam int W  = 3;
    localparam int PW = W + 3;

    logic         clk = 1'b0;
    logic         rstb;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;
    logic         load_err;
`ifdef JK_CNT_GRAY_EN
    logic [W-1:0] count_gray;
`endif

    int checks = 0;
    int errors = 0;
    int vec_n  = 0;
    logic [PW-1:0] exp_q[$];
    int            id_q[$];

    jk_updown_range_counter dut (
        .clk      (clk),
        .rstb     (rstb),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
`ifdef JK_CNT_GRAY_EN
        .count_gray (count_gray),
`endif
        .tc       (tc),
        .wrap     (wrap),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got count=%0d tc=%b wrap=%b load_err=%b, expected count=%0d tc=%b wrap=%b load_err=%b",
                     name, act[PW-1:3], act[2], act[1], act[0], exp[PW-1:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: every clock the DUT presents a new state; compare against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [PW-1:0] e;
            int            id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            check($sformatf("vec%0d", id), {count, tc, wrap, load_err}, e);
`ifdef JK_CNT_GRAY_EN
            checks++;
            if (count_gray !== (e[PW-1:3] ^ (e[PW-1:3] >> 1))) begin
                errors++;
                $display("FAIL vec%0d_gray: got %b expected %b", id, count_gray, e[PW-1:3] ^ (e[PW-1:3] >> 1));
            end
`endif
        end
    end

    task automatic push_exp(input logic [W-1:0] ec, input logic etc, input logic ew, input logic eerr);
        exp_q.push_back({ec, etc, ew, eerr});
        id_q.push_back(vec_n);
        vec_n++;
    endtask

    task automatic vec(input logic e, input logic u, input logic l, input logic [W-1:0] lv,
                       input logic [W-1:0] ec, input logic etc, input logic ew, input logic eerr);
        @(negedge clk);
        en = e; up_dn = u; load = l; load_val = lv;
        push_exp(ec, etc, ew, eerr);
    endtask

    // Corrupt the count register to an illegal value between edges, then let the next edge correct it.
    task automatic corrupt(input logic e, input logic u, input logic l, input logic [W-1:0] lv,
                           input logic [W-1:0] ec, input logic etc);
        @(negedge clk);
        en = e; up_dn = u; load = l; load_val = lv;
        force dut.count_q = 3'd0;
        #1;
        release dut.count_q;
        push_exp(ec, etc, 1'b0, 1'b0);
    endtask

    initial begin
        rstb = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        #3 rstb = 1'b0;
        #1 check("reset", {count, tc, wrap, load_err}, {3'd7, 1'b0, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        rstb = 1'b1;

        // Up count from 7 through the wrap.
        vec(1, 1, 0, 0, 3'd1, 0, 1, 0);
        vec(1, 1, 0, 0, 3'd2, 0, 0, 0);
        vec(1, 1, 0, 0, 3'd3, 0, 0, 0);
        vec(1, 1, 0, 0, 3'd4, 0, 0, 0);
        vec(1, 1, 0, 0, 3'd5, 0, 0, 0);
        vec(1, 1, 0, 0, 3'd6, 0, 0, 0);
        vec(1, 1, 0, 0, 3'd7, 1, 0, 0);
        vec(1, 1, 0, 0, 3'd1, 0, 1, 0);

        // Asynchronous reset mid-cycle while the wrap pulse is high.
        @(negedge clk);
        #2 rstb = 1'b0;
        #1 check("async_reset", {count, tc, wrap, load_err}, {3'd7, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        en = 1'b0;
        rstb = 1'b1;

        // Down count from 2, then reverse direction on the same edge.
        vec(1, 0, 1, 3'd2, 3'd2, 0, 0, 0);
        vec(1, 0, 0, 0,    3'd1, 1, 0, 0);
        vec(1, 0, 0, 0,    3'd7, 0, 1, 0);
        vec(1, 0, 0, 0,    3'd6, 0, 0, 0);
        vec(1, 1, 0, 0,    3'd7, 1, 0, 0);

        // Load overrides enable; out-of-range load holds and pulses load_err.
        vec(1, 1, 1, 3'd4, 3'd4, 0, 0, 0);
        vec(1, 1, 1, 3'd0, 3'd4, 0, 0, 1);
        for (int i = 0; i < 5; i++) vec(0, 1, 0, 0, 3'd4, 0, 0, 0);
        vec(0, 1, 1, 3'd7, 3'd7, 0, 0, 0);
        vec(1, 1, 0, 0,    3'd1, 0, 1, 0);

        // Self-correction: wins over hold, and over load plus enable; never wraps.
        corrupt(0, 1, 0, 0,    3'd1, 0);
        corrupt(1, 0, 1, 3'd5, 3'd1, 0);
        vec(1, 0, 0, 0, 3'd7, 0, 1, 0);
        vec(0, 0, 0, 0, 3'd7, 0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
